bus85_master: RTL and testbench
===============================

BUS85_MASTER -- requirements
Module: bus85_master

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, meaning data and multiplexed AD width.
REQ-002 SHALL have parameter ADDRSIZE, default 16, meaning full address width.
REQ-003 SHALL have parameter WAITMAX, default 255, meaning max consecutive wait states before timeout (1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  1  request strobe; sampled only in IDLE.
REQ-007 SHALL have port wr  input  1  1=write cycle, 0=read cycle.
REQ-008 SHALL have port iom  input  1  1=I/O space, 0=memory space.
REQ-009 SHALL have port addr  input  ADDRSIZE  cycle address.
REQ-010 SHALL have port wdata  input  DATASIZE  write data.
REQ-011 SHALL have port busy  output  1  high from T1 through T3.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  qualifies done; high when the cycle timed out.
REQ-014 SHALL have port rdata  output  DATASIZE  captured read data.
REQ-015 SHALL have port adin  input  DATASIZE  AD bus sampled value.
REQ-016 SHALL have port adout  output  DATASIZE  AD bus drive value.
REQ-017 SHALL have port adoe  output  1  AD bus output enable.
REQ-018 SHALL have port ahi  output  ADDRSIZE-DATASIZE  upper address.
REQ-019 SHALL have ports ale, rd_, wr_, iom_, s1, s0  output  1 each  8085-style bus strobes and status.
REQ-020 SHALL have port ready  input  1  responder ready; low inserts wait states.

Function
REQ-021 SHALL implement FSM states IDLE, T1, T2, TW, T3, all outputs registered.
REQ-022 IDLE: req=1 at edge -> latch addr/wdata/wr/iom, next T1; req=0 -> stay; req ignored in all other states.
REQ-023 T1: ale=1, adoe=1, adout=addr[DATASIZE-1:0], ahi=addr upper bits, iom_=iom, {s1,s0}=10 read / 01 write, rd_=wr_=1.
REQ-024 T2: ale=0, ahi/iom_/s1/s0 held; read: adoe=0, rd_=0; write: adoe=1, adout=wdata, wr_=0.
REQ-025 T2 edge: ready=1 -> T3; ready=0 -> TW, wait counter=1.
REQ-026 TW: outputs as T2; ready=1 -> T3; ready=0 and counter<WAITMAX -> increment, stay; ready=0 and counter=WAITMAX -> T3 with timeout flag set.
REQ-027 T3: outputs as T2; read: rdata<=adin at the T3->IDLE edge (FF..F if timed out); always next IDLE.
REQ-028 T3->IDLE edge: rd_/wr_ return 1, adoe=0, done=1 for exactly one cycle, err=timeout flag; done=0 on other cycles.
REQ-029 Zero-wait latency: req edge to done high = 4 cycles (T1,T2,T3,done); each wait state adds one.
REQ-030 req=1 in the done cycle SHALL be accepted (back-to-back, T1 next cycle).
REQ-031 IDLE outputs: ale=0, rd_=wr_=1, adoe=0, adout=0, ahi=0, iom_=0, {s1,s0}=00, busy=0.
REQ-032 rd_ and wr_ SHALL never be low simultaneously; adoe SHALL be 0 whenever rd_=0.
REQ-033 rdata SHALL hold its value until next completed read; writes do not alter it.

Reset
REQ-034 rst_=0 SHALL immediately force IDLE, IDLE outputs per REQ-031, done=err=0, rdata=0, wait counter=0, regardless of clk.
REQ-035 Reset mid-cycle SHALL abort the cycle without done; first edge after rst_ release runs from IDLE.

Verification
REQ-036 Read mem 0x2000, ready=1, responder drives 0x3C -> T1 ale=1 adout=00 ahi=20 s1s0=10 iom_=0; rd_ low 2 cycles; done at cycle 4, rdata=3C, err=0.
REQ-037 Write I/O 0x0042 data 0xA5, ready=1 -> iom_=1, s1s0=01, wr_ low 2 cycles with adout=A5 adoe=1; done, err=0, rdata unchanged.
REQ-038 Read with ready low 3 cycles after T2 -> exactly 3 TW, rd_ low 5 cycles, done at cycle 7.
REQ-039 WAITMAX=4, ready stuck 0 -> 4 TW then T3, done=1 with err=1, rdata=FF.
REQ-040 Back-to-back: req held high over two requests -> second T1 immediately follows done cycle; req during busy ignored.
REQ-041 rst_ low during T2 of write -> wr_=1, adoe=0, busy=0 immediately, no done pulse; next req completes normally.

Source files
------------

// File: rtl/bus85_master.sv
// 8085-style multiplexed address/data bus master.
// Runs one read or write cycle per request through T1/T2/TW/T3 with wait-state timeout.
module bus85_master #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16,
    parameter int WAITMAX  = 255
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         req,
    input  logic                         wr,
    input  logic                         iom,
    input  logic [ADDRSIZE-1:0]          addr,
    input  logic [DATASIZE-1:0]          wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [DATASIZE-1:0]          rdata,
    input  logic [DATASIZE-1:0]          adin,
    output logic [DATASIZE-1:0]          adout,
    output logic                         adoe,
    output logic [ADDRSIZE-DATASIZE-1:0] ahi,
    output logic                         ale,
    output logic                         rd_,
    output logic                         wr_,
    output logic                         iom_,
    output logic                         s1,
    output logic                         s0,
    input  logic                         ready
);

    localparam int HIW = ADDRSIZE - DATASIZE;
    localparam logic [7:0] WMAX = 8'(WAITMAX);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_TW   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic                tmo_q, tmo_d;
    logic                wr_q, wr_d;
    logic                iom_q, iom_d;
    logic [ADDRSIZE-1:0] addr_q, addr_d;
    logic [DATASIZE-1:0] wdata_q, wdata_d;

    logic                ale_q, ale_d;
    logic                rdn_q, rdn_d;
    logic                wrn_q, wrn_d;
    logic                iomn_q, iomn_d;
    logic                s1_q, s1_d;
    logic                s0_q, s0_d;
    logic                adoe_q, adoe_d;
    logic [DATASIZE-1:0] adout_q, adout_d;
    logic [HIW-1:0]      ahi_q, ahi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATASIZE-1:0] rdata_q, rdata_d;

    // Outputs are registered from the next state, so T1 must see the
    // request fields directly on the accepting edge.
    logic                eff_wr;
    logic                eff_iom;
    logic [ADDRSIZE-1:0] eff_addr;

    assign eff_wr   = (state_q == S_IDLE) ? wr   : wr_q;
    assign eff_iom  = (state_q == S_IDLE) ? iom  : iom_q;
    assign eff_addr = (state_q == S_IDLE) ? addr : addr_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tmo_d   = tmo_q;
        wr_d    = wr_q;
        iom_d   = iom_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_T1;
                    wr_d    = wr;
                    iom_d   = iom;
                    addr_d  = addr;
                    wdata_d = wdata;
                    wcnt_d  = 8'd0;
                    tmo_d   = 1'b0;
                end
            end
            S_T1: begin
                state_d = S_T2;
            end
            S_T2: begin
                if (ready) begin
                    state_d = S_T3;
                end else begin
                    state_d = S_TW;
                    wcnt_d  = 8'd1;
                end
            end
            S_TW: begin
                if (ready) begin
                    state_d = S_T3;
                end else if (wcnt_q < WMAX) begin
                    wcnt_d = wcnt_q + 8'd1;
                end else begin
                    state_d = S_T3;
                    tmo_d   = 1'b1;
                end
            end
            S_T3: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ale_d   = 1'b0;
        rdn_d   = 1'b1;
        wrn_d   = 1'b1;
        iomn_d  = 1'b0;
        s1_d    = 1'b0;
        s0_d    = 1'b0;
        adoe_d  = 1'b0;
        adout_d = '0;
        ahi_d   = '0;
        busy_d  = 1'b0;
        unique case (state_d)
            S_T1: begin
                ale_d   = 1'b1;
                adoe_d  = 1'b1;
                adout_d = eff_addr[DATASIZE-1:0];
                ahi_d   = eff_addr[ADDRSIZE-1:DATASIZE];
                iomn_d  = eff_iom;
                s1_d    = ~eff_wr;
                s0_d    = eff_wr;
                busy_d  = 1'b1;
            end
            S_T2, S_TW, S_T3: begin
                ahi_d  = addr_q[ADDRSIZE-1:DATASIZE];
                iomn_d = iom_q;
                s1_d   = ~wr_q;
                s0_d   = wr_q;
                busy_d = 1'b1;
                if (wr_q) begin
                    adoe_d  = 1'b1;
                    adout_d = wdata_q;
                    wrn_d   = 1'b0;
                end else begin
                    rdn_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        done_d  = (state_q == S_T3);
        err_d   = (state_q == S_T3) & tmo_q;
        rdata_d = rdata_q;
        if ((state_q == S_T3) && !wr_q) begin
            rdata_d = tmo_q ? '1 : adin;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            wcnt_q  <= 8'd0;
            tmo_q   <= 1'b0;
            wr_q    <= 1'b0;
            iom_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
            wr_q    <= wr_d;
            iom_q   <= iom_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ale_q   <= 1'b0;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            iomn_q  <= 1'b0;
            s1_q    <= 1'b0;
            s0_q    <= 1'b0;
            adoe_q  <= 1'b0;
            adout_q <= '0;
            ahi_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ale_q   <= ale_d;
            rdn_q   <= rdn_d;
            wrn_q   <= wrn_d;
            iomn_q  <= iomn_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            adoe_q  <= adoe_d;
            adout_q <= adout_d;
            ahi_q   <= ahi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ale   = ale_q;
    assign rd_   = rdn_q;
    assign wr_   = wrn_q;
    assign iom_  = iomn_q;
    assign s1    = s1_q;
    assign s0    = s0_q;
    assign adoe  = adoe_q;
    assign adout = adout_q;
    assign ahi   = ahi_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_bus85_master.sv
// Bench for bus85_master: scripted bus cycles against a small responder,
// with expected completions queued at request time and checked at done.
module tb_bus85_master;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic        iom = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  adin = '0;
    logic        busy, done, err, adoe, ale, rd_, wr_, iom_, s1, s0;
    logic [7:0]  rdata, adout, ahi;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    typedef struct packed {
        int         lat;
        int         rdlow;
        int         wrlow;
        int         viol;
        int         wbad;
        logic       t1_ale;
        logic       t1_adoe;
        logic       t1_busy;
        logic       t1_iom;
        logic [1:0] t1_s;
        logic [7:0] t1_adout;
        logic [7:0] t1_ahi;
        logic       d_err;
        logic [7:0] d_rdata;
        logic [3:0] d_strb;
    } obs_t;

    exp_t       exp_q[$];
    logic [7:0] model_rdata = 8'h00;

    bus85_master #(.DATASIZE(8), .ADDRSIZE(16), .WAITMAX(4)) dut (
        .clk(clk), .rst_(rst_), .req(req), .wr(wr), .iom(iom),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .adin(adin), .adout(adout), .adoe(adoe), .ahi(ahi),
        .ale(ale), .rd_(rd_), .wr_(wr_), .iom_(iom_), .s1(s1), .s0(s0),
        .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and observes it until done or a cycle budget runs out.
    // The responder holds ready low for the first nwait strobe-low edges.
    task automatic bus_cycle(input logic w, input logic io, input logic [15:0] a,
                             input logic [7:0] wd, input logic [7:0] rsp,
                             input int nwait, output obs_t o);
        o = '0;
        o.lat = -1;
        req = 1'b1; wr = w; iom = io; addr = a; wdata = wd; adin = rsp;
        ready = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            req = 1'b0;
            if (c == 1) begin
                o.t1_ale = ale; o.t1_adoe = adoe; o.t1_busy = busy;
                o.t1_iom = iom_; o.t1_s = {s1, s0};
                o.t1_adout = adout; o.t1_ahi = ahi;
            end
            if (!rd_) o.rdlow = o.rdlow + 1;
            if (!wr_) o.wrlow = o.wrlow + 1;
            if ((!rd_ && !wr_) || (!rd_ && adoe)) o.viol = o.viol + 1;
            if (!wr_ && (adout !== wd || adoe !== 1'b1)) o.wbad = o.wbad + 1;
            if (done) begin
                o.lat = c; o.d_err = err; o.d_rdata = rdata;
                o.d_strb = {rd_, wr_, adoe, busy};
                break;
            end
            ready = ((o.rdlow + o.wrlow) > nwait);
        end
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({ale, rd_, wr_, adoe, iom_, s1, s0, busy, done, err} !== 10'b0110000000) begin
            n_fail++;
            $display("FAIL reset_strobes got %b exp 0110000000",
                     {ale, rd_, wr_, adoe, iom_, s1, s0, busy, done, err});
        end
        n_checks++;
        if ({adout, ahi, rdata} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h exp 000000", {adout, ahi, rdata});
        end
        @(negedge clk);
        rst_ = 1'b1;
        tick();
        n_checks++;
        if ({busy, done, ale} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_no_req got %b exp 000", {busy, done, ale});
        end
    endtask

    task automatic test_read_mem();
        obs_t o;
        exp_t e;
        model_rdata = 8'h3C;
        exp_q.push_back('{err: 1'b0, rdata: 8'h3C});
        bus_cycle(1'b0, 1'b0, 16'h2000, 8'h00, 8'h3C, 0, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.lat !== 4) begin
            n_fail++; $display("FAIL rd_latency got %0d exp 4", o.lat);
        end
        n_checks++;
        if ({o.t1_ale, o.t1_adoe, o.t1_busy, o.t1_iom, o.t1_s, o.t1_adout, o.t1_ahi}
            !== {1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 8'h00, 8'h20}) begin
            n_fail++;
            $display("FAIL rd_t1 got ale%b oe%b bsy%b iom%b s%b ad%h hi%h exp 1 1 1 0 10 00 20",
                     o.t1_ale, o.t1_adoe, o.t1_busy, o.t1_iom, o.t1_s, o.t1_adout, o.t1_ahi);
        end
        n_checks++;
        if (o.rdlow !== 2 || o.wrlow !== 0) begin
            n_fail++; $display("FAIL rd_strobe got rd%0d wr%0d exp rd2 wr0", o.rdlow, o.wrlow);
        end
        n_checks++;
        if ({o.d_err, o.d_rdata} !== {e.err, e.rdata}) begin
            n_fail++; $display("FAIL rd_result got err%b %h exp err%b %h",
                               o.d_err, o.d_rdata, e.err, e.rdata);
        end
        n_checks++;
        if (o.d_strb !== 4'b1100 || o.viol !== 0) begin
            n_fail++; $display("FAIL rd_done_bus got %b viol%0d exp 1100 viol0", o.d_strb, o.viol);
        end
        tick();
        n_checks++;
        if ({done, err, busy, rd_} !== 4'b0001) begin
            n_fail++; $display("FAIL rd_after_done got %b exp 0001", {done, err, busy, rd_});
        end
    endtask

    task automatic test_write_io();
        obs_t o;
        exp_t e;
        exp_q.push_back('{err: 1'b0, rdata: model_rdata});
        bus_cycle(1'b1, 1'b1, 16'h0042, 8'hA5, 8'h5E, 0, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.lat !== 4) begin
            n_fail++; $display("FAIL wr_latency got %0d exp 4", o.lat);
        end
        n_checks++;
        if ({o.t1_iom, o.t1_s, o.t1_adout, o.t1_ahi} !== {1'b1, 2'b01, 8'h42, 8'h00}) begin
            n_fail++; $display("FAIL wr_t1 got iom%b s%b ad%h hi%h exp 1 01 42 00",
                               o.t1_iom, o.t1_s, o.t1_adout, o.t1_ahi);
        end
        n_checks++;
        if (o.wrlow !== 2 || o.rdlow !== 0 || o.wbad !== 0) begin
            n_fail++; $display("FAIL wr_strobe got wr%0d rd%0d bad%0d exp wr2 rd0 bad0",
                               o.wrlow, o.rdlow, o.wbad);
        end
        n_checks++;
        if ({o.d_err, o.d_rdata} !== {e.err, e.rdata}) begin
            n_fail++; $display("FAIL wr_result got err%b %h exp err%b %h",
                               o.d_err, o.d_rdata, e.err, e.rdata);
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        exp_t e;
        model_rdata = 8'h5A;
        exp_q.push_back('{err: 1'b0, rdata: 8'h5A});
        bus_cycle(1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A, 3, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.lat !== 7 || o.rdlow !== 5) begin
            n_fail++; $display("FAIL wait3_timing got lat%0d rd%0d exp lat7 rd5", o.lat, o.rdlow);
        end
        n_checks++;
        if ({o.d_err, o.d_rdata} !== {e.err, e.rdata} || o.viol !== 0) begin
            n_fail++; $display("FAIL wait3_result got err%b %h viol%0d exp err%b %h viol0",
                               o.d_err, o.d_rdata, o.viol, e.err, e.rdata);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        model_rdata = 8'hFF;
        exp_q.push_back('{err: 1'b1, rdata: 8'hFF});
        bus_cycle(1'b0, 1'b0, 16'h8001, 8'h00, 8'h99, 255, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.lat !== 8 || o.rdlow !== 6) begin
            n_fail++; $display("FAIL timeout_timing got lat%0d rd%0d exp lat8 rd6", o.lat, o.rdlow);
        end
        n_checks++;
        if ({o.d_err, o.d_rdata} !== {e.err, e.rdata}) begin
            n_fail++; $display("FAIL timeout_result got err%b %h exp err%b %h",
                               o.d_err, o.d_rdata, e.err, e.rdata);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   dcount;
        dcount = 0;
        exp_q.push_back('{err: 1'b0, rdata: 8'h11});
        exp_q.push_back('{err: 1'b0, rdata: 8'h22});
        model_rdata = 8'h22;
        req = 1'b1; wr = 1'b0; iom = 1'b0; addr = 16'h1A2B; adin = 8'h11; ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (done) dcount++;
            if (c == 1 || c == 6) addr = 16'hFFFF;
            if (c == 4 || c == 8) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({done, err, rdata} !== {1'b1, e.err, e.rdata}) begin
                    n_fail++; $display("FAIL b2b_done%0d got d%b e%b %h exp d1 e%b %h",
                                       c, done, err, rdata, e.err, e.rdata);
                end
            end
            if (c == 4) begin
                addr = 16'h3C4D;
                adin = 8'h22;
            end
            if (c == 5) begin
                n_checks++;
                if ({ale, busy, adout, ahi} !== {1'b1, 1'b1, 8'h4D, 8'h3C}) begin
                    n_fail++; $display("FAIL b2b_t1 got ale%b bsy%b ad%h hi%h exp 1 1 4d 3c",
                                       ale, busy, adout, ahi);
                end
            end
        end
        req = 1'b0;
        n_checks++;
        if (dcount !== 2) begin
            n_fail++; $display("FAIL b2b_done_count got %0d exp 2", dcount);
        end
        tick();
        n_checks++;
        if ({done, busy, ale} !== 3'b000) begin
            n_fail++; $display("FAIL b2b_idle got %b exp 000", {done, busy, ale});
        end
    endtask

    task automatic test_reset_abort();
        obs_t o;
        exp_t e;
        int   dseen;
        dseen = 0;
        req = 1'b1; wr = 1'b1; iom = 1'b1; addr = 16'h0300; wdata = 8'h5A;
        tick();
        req = 1'b0;
        tick();
        n_checks++;
        if ({wr_, adoe, busy} !== 3'b011) begin
            n_fail++; $display("FAIL abort_in_t2 got %b exp 011", {wr_, adoe, busy});
        end
        #2;
        rst_ = 1'b0;
        #1;
        n_checks++;
        if ({wr_, adoe, busy, done, rd_} !== 5'b10001) begin
            n_fail++; $display("FAIL abort_async got %b exp 10001", {wr_, adoe, busy, done, rd_});
        end
        model_rdata = 8'h00;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) dseen++;
        end
        @(negedge clk);
        rst_ = 1'b1;
        tick();
        if (done) dseen++;
        n_checks++;
        if (dseen !== 0 || rdata !== model_rdata) begin
            n_fail++; $display("FAIL abort_no_done got done%0d rdata %h exp done0 rdata %h",
                               dseen, rdata, model_rdata);
        end
        model_rdata = 8'h77;
        exp_q.push_back('{err: 1'b0, rdata: 8'h77});
        bus_cycle(1'b0, 1'b0, 16'h4455, 8'h00, 8'h77, 1, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.lat !== 5 || {o.d_err, o.d_rdata} !== {e.err, e.rdata}) begin
            n_fail++; $display("FAIL abort_recover got lat%0d err%b %h exp lat5 err%b %h",
                               o.lat, o.d_err, o.d_rdata, e.err, e.rdata);
        end
    endtask

    initial begin
        test_reset();
        test_read_mem();
        test_write_io();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
